// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared widths, requester indices and round-robin helper
package cdb_arbiter_pkg;
  localparam int REG_DAT_W = 32;
  localparam int ROB_ADD_W = 5;
  localparam logic [1:0] CDB_SRC_ALU = 2'd0;
  localparam logic [1:0] CDB_SRC_BRU = 2'd1;
  localparam logic [1:0] CDB_SRC_LSB = 2'd2;
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int off, input int n);
    int j;
    j = int'(base) + off;
    return 2'(j >= n ? j - n : j);
  endfunction
endpackage

// File: rtl/cdb_skid_fifo.sv
// cdb_skid_fifo: small power-of-two FIFO exposing occupancy and head entry
module cdb_skid_fifo #(
  parameter int W = 69,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  assign head = mem[rd];
  always_ff @(posedge clk)
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin common-data-bus arbiter with per-requester skid FIFOs
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW = REG_DAT_W,
  parameter int QW = ROB_ADD_W,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              iMp,
  input  logic [NREQ-1:0]   iReq_En,
  input  logic [NREQ*QW-1:0] iReq_Qd,
  input  logic [NREQ*DW-1:0] iReq_Vd,
  input  logic [NREQ*DW-1:0] iReq_Jt,
  output logic [NREQ-1:0]   oReq_Full,
  output logic              oCDB_En,
  output logic [QW-1:0]     oCDB_Qd,
  output logic [DW-1:0]     oCDB_Vd,
  output logic [DW-1:0]     oCDB_Jt,
  output logic [1:0]        oCDB_Src
);
  localparam int EW = QW + 2 * DW;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clr, any, go;
  logic [1:0] ptr, win;
  logic [NREQ-1:0] vld, cand, store, pop;
  logic [CW-1:0] cnt [NREQ];
  logic [EW-1:0] head [NREQ];
  logic [EW-1:0] din [NREQ];
  logic [EW-1:0] sel [NREQ];
  assign clr = rst | (en & iMp);
  assign go = any & en & ~iMp;
  genvar k;
  generate
    for (k = 0; k < NREQ; k++) begin : g_req
      assign din[k] = {iReq_Qd[k*QW +: QW], iReq_Vd[k*DW +: DW], iReq_Jt[k*DW +: DW]};
      assign oReq_Full[k] = cnt[k] == CW'(DEPTH);
      assign vld[k] = en & ~iMp & iReq_En[k] & (iReq_Qd[k*QW +: QW] != '0);
      assign cand[k] = (cnt[k] != '0) | vld[k];
      assign sel[k] = (cnt[k] != '0) ? head[k] : din[k];
      assign pop[k] = go & (win == 2'(k)) & (cnt[k] != '0);
      // a bypassed push goes straight to the bus and is never stored
      assign store[k] = vld[k] & ~oReq_Full[k] & ~(go & (win == 2'(k)) & (cnt[k] == '0));
      cdb_skid_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(clr), .push(store[k]), .pop(pop[k]),
        .din(din[k]), .count(cnt[k]), .head(head[k])
      );
      a_no_full_push: assert property (@(posedge clk) disable iff (clr) !(vld[k] && oReq_Full[k]));
    end
  endgenerate
  always_comb begin
    any = 1'b0;
    win = ptr;
    for (int i = NREQ - 1; i >= 0; i--)
      if (cand[rr_idx(ptr, i, NREQ)]) begin
        any = 1'b1;
        win = rr_idx(ptr, i, NREQ);
      end
  end
  always_ff @(posedge clk)
    if (clr) begin
      ptr <= '0;
      oCDB_En <= 1'b0;
      oCDB_Qd <= '0;
      oCDB_Vd <= '0;
      oCDB_Jt <= '0;
      oCDB_Src <= '0;
    end else if (en) begin
      oCDB_En <= any;
      if (any) begin
        {oCDB_Qd, oCDB_Vd, oCDB_Jt} <= sel[win];
        oCDB_Src <= win;
        ptr <= rr_idx(win, 1, NREQ);
      end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector table plus randomized run against a queue model
module tb_cdb_arbiter;
  localparam int NREQ = 3, DW = 32, QW = 5, DEPTH = 2;
  logic clk = 0, rst = 1, en = 0, mp = 0;
  logic [NREQ-1:0] req_en = '0;
  logic [NREQ*QW-1:0] req_qd = '0;
  logic [NREQ*DW-1:0] req_vd = '0, req_jt = '0;
  logic [NREQ-1:0] full;
  logic cdb_en;
  logic [QW-1:0] cdb_qd;
  logic [DW-1:0] cdb_vd, cdb_jt;
  logic [1:0] cdb_src;
  int tests = 0, fails = 0;

  cdb_arbiter #(.NREQ(NREQ), .DW(DW), .QW(QW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .iMp(mp), .iReq_En(req_en), .iReq_Qd(req_qd),
    .iReq_Vd(req_vd), .iReq_Jt(req_jt), .oReq_Full(full), .oCDB_En(cdb_en),
    .oCDB_Qd(cdb_qd), .oCDB_Vd(cdb_vd), .oCDB_Jt(cdb_jt), .oCDB_Src(cdb_src)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic e, m; logic [2:0] rq; logic [4:0] q0, q1, q2; logic [31:0] j1;
    logic x_en; logic [4:0] x_qd; logic [1:0] x_src; logic [2:0] x_full; logic [31:0] x_jt;
  } vec_t;
  typedef struct packed { logic [4:0] q; logic [31:0] v, j; } ent_t;

  vec_t tv[28];
  ent_t fq[NREQ][$];
  int m_ptr;
  logic m_en; logic [4:0] m_qd; logic [31:0] m_vd, m_jt; logic [1:0] m_src;

  function automatic vec_t v(logic e, logic m, logic [2:0] rq, logic [4:0] q0, q1, q2,
                             logic [31:0] j1, logic x_en, logic [4:0] x_qd, logic [1:0] x_src,
                             logic [2:0] x_full, logic [31:0] x_jt);
    vec_t r;
    r.e = e; r.m = m; r.rq = rq; r.q0 = q0; r.q1 = q1; r.q2 = q2; r.j1 = j1;
    r.x_en = x_en; r.x_qd = x_qd; r.x_src = x_src; r.x_full = x_full; r.x_jt = x_jt;
    return r;
  endfunction

  function automatic logic [31:0] vd_of(logic [4:0] q);
    return q == 0 ? 32'h0 : 32'h0E + 32'(q);
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(logic e, logic m, logic [2:0] rq, logic [4:0] q0, q1, q2,
                       logic [31:0] j0, j1, j2);
    en = e; mp = m; req_en = rq;
    req_qd = {q2, q1, q0};
    req_vd = {32'h0E + 32'(q2), 32'h0E + 32'(q1), 32'h0E + 32'(q0)};
    req_jt = {j2, j1, j0};
  endtask

  task automatic model_clear();
    for (int k = 0; k < NREQ; k++) fq[k].delete();
    m_ptr = 0; m_en = 0; m_qd = 0; m_vd = 0; m_jt = 0; m_src = 0;
  endtask

  // pending results are appended first; the winner then takes the front of its queue
  task automatic model_step(logic e, logic m, logic [2:0] rq, logic [4:0] q[3], logic [31:0] j[3]);
    bit found;
    ent_t x;
    if (!e) return;
    if (m) begin model_clear(); return; end
    for (int k = 0; k < NREQ; k++)
      if (rq[k] && q[k] != 0 && fq[k].size() < DEPTH) begin
        x.q = q[k]; x.v = 32'h0E + 32'(q[k]); x.j = j[k];
        fq[k].push_back(x);
      end
    found = 0;
    for (int i = 0; i < NREQ && !found; i++) begin
      int k;
      k = (m_ptr + i) % NREQ;
      if (fq[k].size() > 0) begin
        x = fq[k].pop_front();
        found = 1; m_qd = x.q; m_vd = x.v; m_jt = x.j; m_src = 2'(k);
        m_ptr = (k + 1) % NREQ;
      end
    end
    m_en = found;
  endtask

  initial begin
    tv[0]  = v(1,0,3'b001, 3,0,0, 0,      1, 3,0,3'b000,0);
    tv[1]  = v(1,0,3'b000, 0,0,0, 0,      0, 3,0,3'b000,0);
    tv[2]  = v(1,1,3'b000, 0,0,0, 0,      0, 0,0,3'b000,0);
    tv[3]  = v(1,0,3'b111, 1,2,4, 0,      1, 1,0,3'b000,0);
    tv[4]  = v(1,0,3'b000, 0,0,0, 0,      1, 2,1,3'b000,0);
    tv[5]  = v(1,0,3'b000, 0,0,0, 0,      1, 4,2,3'b000,0);
    tv[6]  = v(1,0,3'b000, 0,0,0, 0,      0, 4,2,3'b000,0);
    tv[7]  = v(1,0,3'b101, 10,0,5, 0,     1,10,0,3'b000,0);
    tv[8]  = v(1,0,3'b101, 11,0,6, 0,     1, 5,2,3'b000,0);
    tv[9]  = v(1,0,3'b101, 12,0,7, 0,     1,11,0,3'b100,0);
    tv[10] = v(1,0,3'b000, 0,0,0, 0,      1, 6,2,3'b000,0);
    tv[11] = v(1,0,3'b000, 0,0,0, 0,      1,12,0,3'b000,0);
    tv[12] = v(1,0,3'b000, 0,0,0, 0,      1, 7,2,3'b000,0);
    tv[13] = v(1,0,3'b000, 0,0,0, 0,      0, 7,2,3'b000,0);
    tv[14] = v(1,0,3'b111, 20,9,8, 32'h1000, 1,20,0,3'b000,0);
    tv[15] = v(1,0,3'b001, 21,0,0, 0,     1, 9,1,3'b000,32'h1000);
    tv[16] = v(1,0,3'b001, 22,0,0, 0,     1, 8,2,3'b001,0);
    tv[17] = v(1,1,3'b001, 23,0,0, 0,     0, 0,0,3'b000,0);
    tv[18] = v(1,0,3'b000, 0,0,0, 0,      0, 0,0,3'b000,0);
    tv[19] = v(1,0,3'b000, 0,0,0, 0,      0, 0,0,3'b000,0);
    tv[20] = v(1,0,3'b001, 0,0,0, 0,      0, 0,0,3'b000,0);
    tv[21] = v(1,0,3'b000, 0,0,0, 0,      0, 0,0,3'b000,0);
    tv[22] = v(1,0,3'b101, 14,0,15, 0,    1,14,0,3'b000,0);
    tv[23] = v(0,0,3'b000, 0,0,0, 0,      1,14,0,3'b000,0);
    tv[24] = v(0,0,3'b001, 16,0,0, 0,     1,14,0,3'b000,0);
    tv[25] = v(0,0,3'b000, 0,0,0, 0,      1,14,0,3'b000,0);
    tv[26] = v(1,0,3'b000, 0,0,0, 0,      1,15,2,3'b000,0);
    tv[27] = v(1,0,3'b000, 0,0,0, 0,      0,15,2,3'b000,0);

    drive(0,0,3'b000,0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_en", 32'(cdb_en), 0);
    check("reset_qd", 32'(cdb_qd), 0);
    check("reset_vd", cdb_vd, 0);
    check("reset_jt", cdb_jt, 0);
    check("reset_src", 32'(cdb_src), 0);
    check("reset_full", 32'(full), 0);
    rst = 0;

    for (int i = 0; i < 28; i++) begin
      drive(tv[i].e, tv[i].m, tv[i].rq, tv[i].q0, tv[i].q1, tv[i].q2, 0, tv[i].j1, 0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_en", i), 32'(cdb_en), 32'(tv[i].x_en));
      check($sformatf("vec%0d_qd", i), 32'(cdb_qd), 32'(tv[i].x_qd));
      check($sformatf("vec%0d_vd", i), cdb_vd, vd_of(tv[i].x_qd));
      check($sformatf("vec%0d_jt", i), cdb_jt, tv[i].x_jt);
      check($sformatf("vec%0d_src", i), 32'(cdb_src), 32'(tv[i].x_src));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(tv[i].x_full));
    end

    rst = 1;
    drive(0,0,3'b000,0,0,0,0,0,0);
    @(posedge clk);
    #1;
    rst = 0;
    model_clear();
    for (int c = 0; c < 600; c++) begin
      logic e, m;
      logic [2:0] rq;
      logic [4:0] q[3];
      logic [31:0] j[3];
      e = $urandom_range(0, 9) != 0;
      m = $urandom_range(0, 39) == 0;
      for (int k = 0; k < NREQ; k++) begin
        rq[k] = fq[k].size() < DEPTH && $urandom_range(0, 2) != 0;
        q[k] = 5'($urandom_range(0, 31));
        j[k] = k == 1 ? $urandom : 32'h0;
      end
      drive(e, m, rq, q[0], q[1], q[2], j[0], j[1], j[2]);
      @(posedge clk);
      model_step(e, m, rq, q, j);
      #1;
      check("rand_en", 32'(cdb_en), 32'(m_en));
      check("rand_qd", 32'(cdb_qd), 32'(m_qd));
      check("rand_vd", cdb_vd, m_vd);
      check("rand_jt", cdb_jt, m_jt);
      check("rand_src", 32'(cdb_src), 32'(m_src));
      for (int k = 0; k < NREQ; k++)
        check($sformatf("rand_full%0d", k), 32'(full[k]), 32'(fq[k].size() == DEPTH));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Common-data-bus arbiter. Collects completed results (ROB tag, value, jump target) from several execution units: ALU, branch unit, and load path of the LSB.
- Broadcasts at most one result per cycle to the reorder buffer, RS and LSB.
- Each requester owns a small skid FIFO, so bursts never drop results. Round-robin arbitration guarantees forward progress for every unit.
- The whole block is flushed on misprediction.

Parameters:
NREQ, 3, number of requesters (0=ALU, 1=BRU, 2=LSB load)
DW, 32, data / jump-target width (REG_DAT_W)
QW, 5, ROB tag width (ROB_ADD_W); tag 0 is reserved as "no tag"
DEPTH, 2, skid FIFO entries per requester (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  global enable (ready); when low, all state holds
iMp  in  1  misprediction flush from ROB
iReq_En  in  NREQ  result valid, one bit per requester
iReq_Qd  in  NREQ*QW  ROB tag per requester, requester k at bits [k*QW +: QW]
iReq_Vd  in  NREQ*DW  result value per requester
iReq_Jt  in  NREQ*DW  jump target per requester (0 for non-branch)
oReq_Full  out  NREQ  requester k must not assert iReq_En[k] while high
oCDB_En  out  1  broadcast valid (registered)
oCDB_Qd  out  QW  broadcast tag (registered)
oCDB_Vd  out  DW  broadcast value (registered)
oCDB_Jt  out  DW  broadcast jump target (registered)
oCDB_Src  out  2  index of the granted requester (registered, debug/perf)

Behaviour:
- Reset (rst=1 at posedge):
  - all FIFOs empty; round-robin pointer = 0
  - oCDB_En=0, oCDB_Qd=0, oCDB_Vd=0, oCDB_Jt=0, oCDB_Src=0; oReq_Full=0
- Flush (iMp=1, en=1 at posedge): same effect as reset. Any iReq_En in that cycle is discarded.
- en=0: no state or output change, pushes ignored. rst still takes effect.
- Push:
  - if iReq_En[k] and Qd!=0, the entry {Qd,Vd,Jt} is written at the FIFO tail.
  - iReq_En[k] with Qd==0 is ignored.
  - a push while full is a protocol violation: entry dropped, simulation assertion fires.
- oReq_Full[k] is combinational: count[k]==DEPTH.
- Candidates:
  - requester k is a candidate if count[k]>0 (head entry) or count[k]==0 and a valid push is arriving this cycle (bypass).
  - bypass gives 1-cycle latency: a result presented at edge t appears on oCDB_* after edge t+1.
- Grant: the first candidate scanning k = ptr, ptr+1, ..., wrapping mod NREQ.
  - winner's head (or bypass data) is registered onto oCDB_* with oCDB_En=1, oCDB_Src=k.
  - winner pops; ptr <= (k+1) mod NREQ.
- No candidate: oCDB_En<=0, other oCDB_* hold their previous value, ptr unchanged.
- Simultaneous push and pop on the same FIFO: count unchanged. A bypassed push is not stored.
- Ordering: FIFO order within a requester is preserved. There is no ordering guarantee across requesters.
- Pointers wrap at DEPTH. Counts are QW-independent, width clog2(DEPTH)+1.
- Worst-case wait for a non-empty requester: NREQ-1 cycles.

Decomposition:
- Shared header (header.vh) supplies REG_DAT_W and ROB_ADD_W. Parameter defaults take these values.
- Add a `CDB_SRC_ALU/BRU/LSB` index to the shared header.
- One sub-module, cdb_skid_fifo (width QW+2*DW, depth DEPTH), exposes count, head, push, pop. It is instantiated NREQ times via generate.
- Round-robin selection stays in the top module.

Test Plan:
1. Reset then ALU only: ALU pushes Qd=3, Vd=0x11 at cycle 1 -> cycle 2: oCDB_En=1, Qd=3, Vd=0x11, Src=0; cycle 3: oCDB_En=0.
2. All three push in one cycle (Qd=1,2,4), ptr=0 -> broadcasts Qd=1,2,4 in consecutive cycles, Src=0,1,2; then ptr=0.
3. LSB pushes Qd=5,6,7 on back-to-back cycles while ALU pushes every cycle -> results alternate ALU/LSB. LSB FIFO reaches 2 and oReq_Full[2]=1 for one cycle. No LSB result is lost; LSB order is 5,6,7.
4. BRU pushes Qd=9, Jt=0x1000 while the FIFOs hold 2 ALU entries; iMp=1 next cycle -> following cycle oCDB_En=0, all counts 0, ptr 0, no stale broadcast afterwards.
5. Push with Qd=0 -> never broadcast. en=0 for 3 cycles with a pending entry -> outputs frozen, entry broadcast on the first en=1 cycle.
6. Push on a full FIFO -> assertion fires and the count stays at DEPTH.
